// File: rtl/layernorm_denorm_seq.sv
// layernorm_denorm_seq: rebuilds activations as sat(norm*std_dev + mean), one element per cycle
module layernorm_denorm_seq #(
  parameter int LEN = 8,
  parameter int W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LEN-1:0][W-1:0]     in_vec,
  input  logic [W-1:0]              mean,
  input  logic [W-1:0]              std_dev,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LEN-1:0][W-1:0]     out_vec,
  output logic                      out_sat
);
  localparam int IW = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [LEN-1:0][W-1:0] vec_q, out_vec_q;
  logic [W-1:0]         mean_q, std_q;
  logic                 out_valid_q, out_sat_q;
  logic signed [2*W:0]  prod_d, scaled_d;
  logic signed [2*W+1:0] sum_d;
  logic [W-1:0]         elem_d;
  logic                 sat_d;
  // Result fits in W bits only when all bits from the sign down to bit W-1 agree
  always_comb begin
    prod_d   = (2*W+1)'($signed(vec_q[idx_q])) * (2*W+1)'($signed({1'b0, std_q}));
    scaled_d = prod_d >>> 8;
    sum_d    = (2*W+2)'(scaled_d) + (2*W+2)'($signed(mean_q));
    sat_d    = !((&sum_d[2*W+1:W-1]) || !(|sum_d[2*W+1:W-1]));
    elem_d   = !sat_d ? sum_d[W-1:0] : sum_d[2*W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vec_q       <= '0;
      mean_q      <= '0;
      std_q       <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          vec_q     <= in_vec;
          mean_q    <= mean;
          std_q     <= std_dev;
          idx_q     <= '0;
          out_sat_q <= 1'b0;
          state_q   <= RUN;
        end
        RUN: begin
          out_vec_q[idx_q] <= elem_d;
          out_sat_q        <= out_sat_q | sat_d;
          idx_q            <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign out_sat   = out_sat_q;
endmodule
